ntt_stream_sched: RTL and testbench

- Per-polynomial scheduler for the single-path delay-feedback NTT/INTT pipeline.
- Accepts one coefficient per beat and advances the whole pipeline on one global advance strobe.
- Drives the per-stage FIFO enables (fifo_en) and butterfly switch selects.
- Flushes the pipeline after the last input beat and frames the output stream with valid/last/done.

---
 rtl/ntt_stream_sched_if.sv | 26 ++
 rtl/ntt_stream_sched.sv | 126 ++++++++++++
 tb/tb_ntt_stream_sched.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ntt_stream_sched_if.sv
// Handshake and pipeline-control bundle between the NTT stream scheduler and its datapath/host.
interface ntt_stream_sched_if #(
   parameter int STAGE_CNT = 7
);
   logic                 mode;
   logic                 in_valid;
   logic                 in_ready;
   logic                 out_ready;
   logic                 out_valid;
   logic                 out_last;
   logic [STAGE_CNT-1:0] stage_en;
   logic [STAGE_CNT-1:0] sw;
   logic                 mode_q;
   logic                 busy;
   logic                 done;

   modport master (
      input  mode, in_valid, out_ready,
      output in_ready, out_valid, out_last, stage_en, sw, mode_q, busy, done
   );

   modport slave (
      output mode, in_valid, out_ready,
      input  in_ready, out_valid, out_last, stage_en, sw, mode_q, busy, done
   );
endinterface

// File: rtl/ntt_stream_sched.sv
// Per-polynomial scheduler for a single-path delay-feedback NTT/INTT pipeline.
// Drives per-stage FIFO enables and butterfly selects, then flushes and frames the output.
//
//   state | meaning
//   IDLE  | waiting for the first coefficient of a polynomial
//   LOAD  | accepting coefficients; pipeline advances only on accepted beats
//   DRAIN | flushing; advances while no output is pending or downstream is ready
module ntt_stream_sched #(
   parameter int STAGE_CNT = 7,
   parameter int MUL_LAT   = 3,
   parameter int T_BITS    = $clog2(2**STAGE_CNT + (2**STAGE_CNT - 1 + STAGE_CNT*MUL_LAT))
) (
   input logic                clk,
   input logic                rst,
   ntt_stream_sched_if.master bus
);
   localparam int POLY_LEN  = 2**STAGE_CNT;
   localparam int TOTAL_LAT = POLY_LEN - 1 + STAGE_CNT*MUL_LAT;

   localparam logic [T_BITS-1:0] TOTAL_T = T_BITS'(TOTAL_LAT);
   localparam logic [T_BITS-1:0] LAST_T  = T_BITS'(TOTAL_LAT + POLY_LEN - 1);
   localparam logic [T_BITS-1:0] LOAD_T  = T_BITS'(POLY_LEN - 1);

   // Start time of stage s: sum over earlier stages of their feedback depth plus multiplier latency.
   function automatic int stage_off(input int s, input bit inv);
      int acc;
      acc = 0;
      for (int k = 0; k < s; k++)
         acc += 2**(inv ? k : STAGE_CNT-1-k) + MUL_LAT;
      return acc;
   endfunction

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

   state_t              state, state_nxt;
   logic [T_BITS-1:0]   t;
   logic                mode_q;
   logic                done;
   logic                adv;
   logic                in_rdy;
   logic                out_cond;
   logic                out_vld;
   logic                out_lst;
   logic                fin;
   logic [STAGE_CNT-1:0] en_v;
   logic [STAGE_CNT-1:0] sw_v;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      adv       = 1'b0;
      in_rdy    = 1'b0;
      out_cond  = (t >= TOTAL_T);
      out_vld   = (state == DRAIN) & out_cond;
      out_lst   = out_vld & (t == LAST_T);
      fin       = out_lst & bus.out_ready;
      case (state)
         IDLE: begin
            in_rdy = ~rst;
            adv    = bus.in_valid & ~rst;
            if (adv) state_nxt = (POLY_LEN == 1) ? DRAIN : LOAD;
         end
         LOAD: begin
            in_rdy = ~rst;
            adv    = bus.in_valid & ~rst;
            if (adv && t == LOAD_T) state_nxt = DRAIN;
         end
         DRAIN: begin
            adv = ~out_cond | bus.out_ready;
            if (fin) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t      <= '0;
         mode_q <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= fin;
         if (state == IDLE && adv) begin
            mode_q <= bus.mode;
            t      <= T_BITS'(1);
         end else if (fin) begin
            t <= '0;
         end else if (adv) begin
            t <= t + T_BITS'(1);
         end
      end
   end

   // Both mode offset sets are constants; only the mux on mode_q is live logic.
   for (genvar s = 0; s < STAGE_CNT; s++) begin : g_stage
      localparam logic [T_BITS-1:0] OFF_N  = T_BITS'(stage_off(s, 1'b0));
      localparam logic [T_BITS-1:0] OFF_I  = T_BITS'(stage_off(s, 1'b1));
      localparam logic [T_BITS-1:0] END_N  = T_BITS'(stage_off(s, 1'b0) + POLY_LEN);
      localparam logic [T_BITS-1:0] END_I  = T_BITS'(stage_off(s, 1'b1) + POLY_LEN);
      localparam logic [T_BITS-1:0] MASK_N = T_BITS'(2**(STAGE_CNT-1-s));
      localparam logic [T_BITS-1:0] MASK_I = T_BITS'(2**s);

      logic [T_BITS-1:0] off;
      logic [T_BITS-1:0] off_end;
      logic [T_BITS-1:0] mask;

      assign off     = mode_q ? OFF_I  : OFF_N;
      assign off_end = mode_q ? END_I  : END_N;
      assign mask    = mode_q ? MASK_I : MASK_N;
      assign en_v[s] = adv & (t >= off) & (t < off_end);
      assign sw_v[s] = en_v[s] & (|((t - off) & mask));
   end

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_vld;
   assign bus.out_last  = out_lst;
   assign bus.stage_en  = en_v;
   assign bus.sw        = sw_v;
   assign bus.mode_q    = mode_q;
   assign bus.busy      = (state != IDLE);
   assign bus.done      = done;
endmodule

// File: tb/tb_ntt_stream_sched.sv
// Directed bench for ntt_stream_sched with STAGE_CNT=7, MUL_LAT=3 (POLY_LEN=128, TOTAL_LAT=148).
module tb_ntt_stream_sched;
   localparam int PLEN  = 128;
   localparam int TLAT  = 148;
   localparam int OFF_N [7] = '{0, 67, 102, 121, 132, 139, 144};
   localparam int OFF_I [7] = '{0, 4, 9, 16, 27, 46, 81};

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   ntt_stream_sched_if #(.STAGE_CNT(7)) bus ();

   ntt_stream_sched #(.STAGE_CNT(7), .MUL_LAT(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] exp_en(input int t, input bit m, input bit a);
      logic [6:0] r;
      int off;
      r = '0;
      for (int s = 0; s < 7; s++) begin
         off  = m ? OFF_I[s] : OFF_N[s];
         r[s] = a && (t >= off) && (t < off + PLEN);
      end
      return r;
   endfunction

   function automatic logic [6:0] exp_sw(input int t, input bit m, input bit a);
      logic [6:0] en;
      logic [6:0] r;
      int off;
      int b;
      en = exp_en(t, m, a);
      r  = '0;
      for (int s = 0; s < 7; s++) begin
         off  = m ? OFF_I[s] : OFF_N[s];
         b    = m ? s : 6 - s;
         r[s] = en[s] && (((t - off) >> b) & 1);
      end
      return r;
   endfunction

   // One polynomial. abort_at>0 returns mid-load at that t; exp_cyc>0 checks total cycles to done.
   task automatic run_poly(input bit m, input bit bubbles, input int bp_at,
                           input int abort_at, input int exp_cyc);
      int t_exp, beats, outs, cyc, guard, bp_left;
      bit iv, adv, ordy, ov_e, fin;
      t_exp = 0; beats = 0; outs = 0; cyc = 0; guard = 0; bp_left = 10; fin = 0;
      while (beats < PLEN && guard < 2000) begin
         if (abort_at > 0 && t_exp == abort_at) return;
         iv            = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.in_valid  = iv;
         bus.mode      = (beats == 0) ? m : ~m;
         bus.out_ready = 1'b1;
         #1;
         chk("load_in_ready", bus.in_ready, 1);
         chk("load_out_valid", bus.out_valid, 0);
         chk("load_stage_en", bus.stage_en, exp_en(t_exp, m, iv));
         chk("load_sw", bus.sw, exp_sw(t_exp, m, iv));
         if (beats > 0) begin
            chk("load_mode_q", bus.mode_q, m);
            chk("load_busy", bus.busy, 1);
         end
         if (iv || beats > 0) cyc++;
         @(posedge clk); #1;
         if (iv) begin
            beats++;
            t_exp++;
         end
         guard++;
      end
      chk("load_beats", beats, PLEN);
      bus.in_valid = 1'b0;
      guard = 0;
      while (!fin && guard < 1000) begin
         ordy = !(bp_at > 0 && t_exp == bp_at && bp_left > 0);
         if (!ordy) bp_left--;
         bus.out_ready = ordy;
         bus.mode      = ~m;
         #1;
         ov_e = (t_exp >= TLAT);
         adv  = !ov_e || ordy;
         chk("drain_in_ready", bus.in_ready, 0);
         chk("drain_out_valid", bus.out_valid, ov_e);
         chk("drain_out_last", bus.out_last, ov_e && t_exp == TLAT + PLEN - 1);
         chk("drain_stage_en", bus.stage_en, exp_en(t_exp, m, adv));
         chk("drain_sw", bus.sw, exp_sw(t_exp, m, adv));
         chk("drain_mode_q", bus.mode_q, m);
         chk("drain_busy", bus.busy, 1);
         if (bus.out_valid && ordy) outs++;
         fin = bus.out_last && ordy;
         cyc++;
         @(posedge clk); #1;
         if (adv) t_exp++;
         guard++;
      end
      bus.out_ready = 1'b1;
      #1;
      chk("out_beats", outs, PLEN);
      chk("done_pulse", bus.done, 1);
      chk("end_busy", bus.busy, 0);
      chk("end_in_ready", bus.in_ready, 1);
      if (exp_cyc > 0) chk("poly_cycles", cyc, exp_cyc);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clk    = 1'b0;
      rst    = 1'b1;
      bus.in_valid  = 1'b1;
      bus.mode      = 1'b1;
      bus.out_ready = 1'b1;
      #12;
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_stage_en", bus.stage_en, 0);
      chk("rst_sw", bus.sw, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_mode_q", bus.mode_q, 0);
      chk("rst_done", bus.done, 0);
      bus.in_valid = 1'b0;
      #4 rst = 1'b0;
      @(posedge clk); #1;

      // NTT continuous: 128 load + 148 drain cycles
      run_poly(1'b0, 1'b0, 0, 0, 276);
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("done_one_cycle", bus.done, 0);

      // INTT with mode toggling after the first beat
      run_poly(1'b1, 1'b0, 0, 0, 276);
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("intt_mode_q_held", bus.mode_q, 1);

      // Input bubbles
      run_poly(1'b0, 1'b1, 0, 0, 0);
      bus.in_valid = 1'b0;
      @(posedge clk); #1;

      // Backpressure for 10 cycles at t=200
      run_poly(1'b0, 1'b0, 200, 0, 286);
      bus.in_valid = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of LOAD at t=90
      run_poly(1'b1, 1'b0, 0, 90, 0);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_in_ready", bus.in_ready, 0);
      chk("mid_rst_stage_en", bus.stage_en, 0);
      chk("mid_rst_mode_q", bus.mode_q, 0);
      chk("mid_rst_done", bus.done, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("post_rst_in_ready", bus.in_ready, 1);
      chk("post_rst_busy", bus.busy, 0);
      @(posedge clk); #1;
      chk("post_rst_done", bus.done, 0);
      chk("post_rst_busy2", bus.busy, 0);

      // Back-to-back: INTT first beat accepted in the NTT done cycle
      run_poly(1'b0, 1'b0, 0, 0, 276);
      run_poly(1'b1, 1'b0, 0, 0, 276);
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("b2b_mode_q", bus.mode_q, 1);
      chk("b2b_done_clear", bus.done, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
